// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmitter and receive path.
//   - ps2_tx_state_t : transmitter FSM states (also exported on the debug port)
//   - ERR_*          : err_code values reported by ps2_host_tx
//   - PS2_CMD_*      : common host-to-keyboard command bytes
//   - max3           : constant helper used to size the shared timer
package ps2_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INHIBIT   = 4'd1,
        ST_RTS       = 4'd2,
        ST_DATA      = 4'd3,
        ST_PARITY    = 4'd4,
        ST_STOP      = 4'd5,
        ST_WAIT_IDLE = 4'd6,
        ST_DONE      = 4'd7,
        ST_ABORT     = 4'd8
    } ps2_tx_state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_START_TO = 2'b01;
    localparam logic [1:0] ERR_FRAME_TO = 2'b10;
    localparam logic [1:0] ERR_NACK     = 2'b11;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: brings the raw open-drain PS/2 pins into the CLK domain.
//   CLK, reset_keyboard : system clock, asynchronous active-high reset
//   ps2_clk_in/dat_in   : raw pin levels (asynchronous)
//   clk_sync/dat_sync   : 2-FF synchronised levels (reset to the idle level 1)
//   clk_fall            : 1-cycle strobe on a 1->0 transition of clk_sync
module ps2_line_sync (
    input  logic CLK,
    input  logic reset_keyboard,
    input  logic ps2_clk_in,
    input  logic ps2_dat_in,
    output logic clk_sync,
    output logic dat_sync,
    output logic clk_fall
);

    logic [1:0] clk_ff;
    logic [1:0] dat_ff;
    logic       clk_prev;

    always_ff @(posedge CLK or posedge reset_keyboard) begin
        if (reset_keyboard) begin
            clk_ff   <= 2'b11;
            dat_ff   <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], ps2_clk_in};
            dat_ff   <= {dat_ff[0], ps2_dat_in};
            clk_prev <= clk_ff[1];
        end
    end

    assign clk_sync = clk_ff[1];
    assign dat_sync = dat_ff[1];
    assign clk_fall = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter for one command byte.
//   CLK, reset_keyboard      : system clock, asynchronous active-high reset
//   cmd_data/valid/ready     : command input handshake
//   ps2_clk_in/ps2_dat_in    : raw pin levels
//   clk_drive_low/dat_drive_low : open-drain pull-down enables for the pins
//   busy                     : high outside IDLE; receive path ignores the lines
//   tx_done/tx_error         : 1-cycle completion / abort pulses
//   err_code                 : reason of the last abort, cleared on accept
//   dbg_state                : current FSM state
//
// Handshake: a command is taken on a rising CLK edge where cmd_valid and
// cmd_ready are both high. cmd_ready depends only on the state (high in IDLE),
// never on cmd_valid. cmd_valid seen while busy is dropped, not queued.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES       = 5000,
    parameter int START_TIMEOUT_CYCLES = 750000,
    parameter int FRAME_TIMEOUT_CYCLES = 100000
) (
    input  logic          CLK,
    input  logic          reset_keyboard,
    input  logic [7:0]    cmd_data,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          ps2_clk_in,
    input  logic          ps2_dat_in,
    output logic          clk_drive_low,
    output logic          dat_drive_low,
    output logic          busy,
    output logic          tx_done,
    output logic          tx_error,
    output logic [1:0]    err_code,
    output ps2_tx_state_t dbg_state
);

    localparam int TW = $clog2(max3(INHIBIT_CYCLES, START_TIMEOUT_CYCLES,
                                    FRAME_TIMEOUT_CYCLES) + 1);
    localparam logic [TW-1:0] INH_LAST   = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] INH_PRE    = TW'(INHIBIT_CYCLES - 2);
    localparam logic [TW-1:0] START_LAST = TW'(START_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] FRAME_LAST = TW'(FRAME_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMR_MAX    = '1;

    ps2_tx_state_t state;
    logic [8:0]    shift_q;    // {parity, data}, shifted out LSB first
    logic [3:0]    edge_cnt;   // device falling edges seen in this frame
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_inc;
    logic          clk_sync;
    logic          dat_sync;
    logic          clk_fall;

    ps2_line_sync u_sync (
        .CLK            (CLK),
        .reset_keyboard (reset_keyboard),
        .ps2_clk_in     (ps2_clk_in),
        .ps2_dat_in     (ps2_dat_in),
        .clk_sync       (clk_sync),
        .dat_sync       (dat_sync),
        .clk_fall       (clk_fall)
    );

    // Saturating increment: the timer never wraps back to zero.
    assign timer_inc = (timer == TMR_MAX) ? timer : timer + 1'b1;
    assign dbg_state = state;

    always_ff @(posedge CLK or posedge reset_keyboard) begin
        if (reset_keyboard) begin
            state         <= ST_IDLE;
            shift_q       <= '0;
            edge_cnt      <= '0;
            timer         <= '0;
            cmd_ready     <= 1'b1;
            clk_drive_low <= 1'b0;
            dat_drive_low <= 1'b0;
            busy          <= 1'b0;
            tx_done       <= 1'b0;
            tx_error      <= 1'b0;
            err_code      <= ERR_NONE;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        shift_q       <= {~^cmd_data, cmd_data};
                        err_code      <= ERR_NONE;
                        edge_cnt      <= '0;
                        timer         <= '0;
                        busy          <= 1'b1;
                        cmd_ready     <= 1'b0;
                        clk_drive_low <= 1'b1;
                        // A one-cycle inhibit already is its own last cycle.
                        dat_drive_low <= (INHIBIT_CYCLES == 1);
                        state         <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (timer == INH_LAST) begin
                        clk_drive_low <= 1'b0;   // data stays low: start bit
                        timer         <= '0;
                        state         <= ST_RTS;
                    end else begin
                        timer <= timer_inc;
                        if (timer == INH_PRE) dat_drive_low <= 1'b1;
                    end
                end
                ST_RTS: begin
                    if (clk_fall) begin
                        dat_drive_low <= ~shift_q[0];
                        shift_q       <= {1'b0, shift_q[8:1]};
                        edge_cnt      <= 4'd1;
                        timer         <= '0;     // frame timer starts here
                        state         <= ST_DATA;
                    end else if (timer == START_LAST) begin
                        dat_drive_low <= 1'b0;
                        tx_error      <= 1'b1;
                        err_code      <= ERR_START_TO;
                        state         <= ST_ABORT;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_IDLE: begin
                    if (timer == FRAME_LAST) begin
                        dat_drive_low <= 1'b0;
                        tx_error      <= 1'b1;
                        err_code      <= ERR_FRAME_TO;
                        state         <= ST_ABORT;
                    end else begin
                        timer <= timer_inc;
                        if (state == ST_WAIT_IDLE) begin
                            if (clk_sync && dat_sync) begin
                                tx_done <= 1'b1;
                                state   <= ST_DONE;
                            end
                        end else if (clk_fall) begin
                            edge_cnt <= edge_cnt + 4'd1;
                            if (state == ST_DATA) begin
                                // After bit7 shift_q[0] holds the parity bit.
                                dat_drive_low <= ~shift_q[0];
                                shift_q       <= {1'b0, shift_q[8:1]};
                                if (edge_cnt == 4'd8) state <= ST_PARITY;
                            end else if (state == ST_PARITY) begin
                                dat_drive_low <= 1'b0;   // stop bit = 1
                                state         <= ST_STOP;
                            end else if (!dat_sync) begin
                                state <= ST_WAIT_IDLE;   // device ACK
                            end else begin
                                tx_error <= 1'b1;
                                err_code <= ERR_NACK;
                                state    <= ST_ABORT;
                            end
                        end
                    end
                end
                ST_DONE, ST_ABORT: begin
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    clk_drive_low <= 1'b0;
                    dat_drive_low <= 1'b0;
                    busy          <= 1'b0;
                    cmd_ready     <= 1'b1;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH      = 50;
    localparam int START_TO = 2000;
    localparam int FRAME_TO = 20000;
    localparam int DEV_HALF = 100;   // scaled device clock half-period in CLK cycles

    logic          CLK = 1'b0;
    logic          reset_keyboard = 1'b1;
    logic [7:0]    cmd_data = 8'h00;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          ps2_clk_in;
    logic          ps2_dat_in;
    logic          clk_drive_low;
    logic          dat_drive_low;
    logic          busy;
    logic          tx_done;
    logic          tx_error;
    logic [1:0]    err_code;
    ps2_tx_state_t dbg_state;

    // Device side of the open-drain pair
    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;
    assign ps2_clk_in = dev_clk & ~clk_drive_low;
    assign ps2_dat_in = dev_dat & ~dat_drive_low;

    ps2_host_tx #(
        .INHIBIT_CYCLES       (INH),
        .START_TIMEOUT_CYCLES (START_TO),
        .FRAME_TIMEOUT_CYCLES (FRAME_TO)
    ) dut (
        .CLK            (CLK),
        .reset_keyboard (reset_keyboard),
        .cmd_data       (cmd_data),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .ps2_clk_in     (ps2_clk_in),
        .ps2_dat_in     (ps2_dat_in),
        .clk_drive_low  (clk_drive_low),
        .dat_drive_low  (dat_drive_low),
        .busy           (busy),
        .tx_done        (tx_done),
        .tx_error       (tx_error),
        .err_code       (err_code),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #10 CLK = ~CLK;   // 50 MHz

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        repeat (95000) @(posedge CLK);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    // ---------------- monitor ----------------
    int   done_pulses = 0, err_pulses = 0, wide_pulses = 0;
    int   inhibit_starts = 0, inh_run = 0, last_inh_len = 0;
    logic done_q = 1'b0, err_q = 1'b0, cdl_q = 1'b0;
    int   first_fall_cyc = 0;

    always @(negedge CLK) begin
        if (tx_done && !done_q) done_pulses++;
        if (tx_error && !err_q) err_pulses++;
        if ((tx_done && done_q) || (tx_error && err_q)) wide_pulses++;
        if (clk_drive_low && !cdl_q) begin
            inhibit_starts++;
            inh_run = 1;
        end else if (clk_drive_low) begin
            inh_run++;
        end else if (cdl_q) begin
            last_inh_len = inh_run;
        end
        done_q = tx_done;
        err_q  = tx_error;
        cdl_q  = clk_drive_low;
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference model: frame as the device sees it, {stop, parity, d7..d0, start}.
    // Odd parity: the parity bit makes the total number of ones odd.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2) == 0;
        return {1'b1, par, b, 1'b0};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [7:0] b);
        int n;
        n = 0;
        while (!cmd_ready && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        cmd_data  = b;
        cmd_valid = 1'b1;
        @(negedge CLK);
        cmd_valid = 1'b0;
        cmd_data  = 8'($urandom);
    endtask

    task automatic wait_rts(output bit got);
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge CLK);
            if (!clk_drive_low && dat_drive_low) got = 1'b1;
        end
    endtask

    // Device model: n_edges clock pulses; samples the line before each fall,
    // answers with ACK (data low) before the 11th fall when ack is set.
    task automatic dev_frame(input int n_edges, input bit ack,
                             output logic [10:0] bits, output bit got_rts);
        bits = '1;
        wait_rts(got_rts);
        if (!got_rts) return;
        repeat (DEV_HALF) @(negedge CLK);
        for (int k = 0; k < n_edges; k++) begin
            bits[k] = ps2_dat_in;
            if (k == 10 && ack) dev_dat = 1'b0;
            repeat (DEV_HALF / 2) @(negedge CLK);
            dev_clk = 1'b0;
            if (k == 0) first_fall_cyc = cyc;
            repeat (DEV_HALF) @(negedge CLK);
            dev_clk = 1'b1;
            repeat (DEV_HALF / 2) @(negedge CLK);
        end
        dev_dat = 1'b1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < FRAME_TO + 5000 && !ok; i++) begin
            @(negedge CLK);
            if (cmd_ready && !busy) ok = 1'b1;
        end
    endtask

    task automatic run_txn(input string name, input logic [7:0] b, input int edges,
                           input bit ack, input logic [1:0] exp_err, input int exp_done);
        logic [10:0] bits;
        bit          got, ok;
        int          d0, e0;
        d0 = done_pulses;
        e0 = err_pulses;
        send_cmd(b);
        dev_frame(edges, ack, bits, got);
        check({name, "_rts"}, got, 1);
        wait_idle(ok);
        check({name, "_idle"}, ok, 1);
        check({name, "_inhibit_len"}, last_inh_len, INH);
        if (edges == 11) check({name, "_frame_bits"}, bits, exp_frame(b));
        check({name, "_done_pulses"}, done_pulses - d0, exp_done);
        check({name, "_err_pulses"}, err_pulses - e0, (exp_err != ERR_NONE) ? 1 : 0);
        check({name, "_err_code"}, err_code, exp_err);
        check({name, "_lines_released"}, {clk_drive_low, dat_drive_low}, 2'b00);
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        logic [7:0] cmd;
        int         edges;
        bit         ack;
        logic [1:0] exp_err;
        int         exp_done;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int          t_rel, t_err, n, s0, d0, e0;
        bit          got, ok;
        logic [10:0] bits;
        logic [7:0]  rb;
        bit          rack;

        vecs.push_back('{PS2_CMD_SET_LEDS, 11, 1'b1, ERR_NONE, 1});
        vecs.push_back('{8'h00,            11, 1'b1, ERR_NONE, 1});
        vecs.push_back('{8'h01,            11, 1'b1, ERR_NONE, 1});
        vecs.push_back('{PS2_CMD_RESET,    11, 1'b0, ERR_NACK, 0});
        vecs.push_back('{PS2_CMD_ENABLE,   11, 1'b1, ERR_NONE, 1});
        vecs.push_back('{PS2_ACK_BYTE,     11, 1'b1, ERR_NONE, 1});
        for (int i = 0; i < 4; i++) begin
            rb   = 8'($urandom);
            rack = ($urandom_range(0, 3) != 0);
            vecs.push_back('{rb, 11, rack, rack ? ERR_NONE : ERR_NACK, rack ? 1 : 0});
        end

        // Reset state
        repeat (5) @(negedge CLK);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_lines", {clk_drive_low, dat_drive_low}, 2'b00);
        check("reset_busy", busy, 0);
        check("reset_pulses", {tx_done, tx_error}, 2'b00);
        check("reset_err_code", err_code, ERR_NONE);
        @(negedge CLK);
        reset_keyboard = 1'b0;
        repeat (3) @(negedge CLK);

        foreach (vecs[i])
            run_txn($sformatf("vec%0d_%02h", i, vecs[i].cmd), vecs[i].cmd, vecs[i].edges,
                    vecs[i].ack, vecs[i].exp_err, vecs[i].exp_done);

        // Start timeout: device never clocks after RTS
        e0 = err_pulses;
        send_cmd(8'h55);
        wait_rts(got);
        check("start_to_rts", got, 1);
        t_rel = cyc;
        n = 0;
        while (!tx_error && n < START_TO + 100) begin
            @(negedge CLK);
            n++;
        end
        t_err = cyc;
        check("start_to_seen", tx_error, 1);
        check_range("start_to_latency", t_err - t_rel, START_TO - 2, START_TO + 2);
        check("start_to_err_code", err_code, ERR_START_TO);
        check("start_to_lines", {clk_drive_low, dat_drive_low}, 2'b00);
        wait_idle(ok);
        check("start_to_err_pulses", err_pulses - e0, 1);

        // Frame timeout: device stops after 5 edges
        e0 = err_pulses;
        d0 = done_pulses;
        send_cmd(8'hA5);
        dev_frame(5, 1'b1, bits, got);
        check("frame_to_rts", got, 1);
        n = 0;
        while (!tx_error && n < FRAME_TO + 200) begin
            @(negedge CLK);
            n++;
        end
        check("frame_to_seen", tx_error, 1);
        check_range("frame_to_latency", cyc - first_fall_cyc, FRAME_TO, FRAME_TO + 8);
        check("frame_to_err_code", err_code, ERR_FRAME_TO);
        check("frame_to_lines", {clk_drive_low, dat_drive_low}, 2'b00);
        wait_idle(ok);
        check("frame_to_pulses", {err_pulses - e0, done_pulses - d0}, {32'd1, 32'd0});

        // Reset during INHIBIT
        send_cmd(8'h3C);
        repeat (10) @(negedge CLK);
        check("rst_inh_pre_clk_low", clk_drive_low, 1);
        #5 reset_keyboard = 1'b1;
        #1;
        check("rst_inh_clk_released", clk_drive_low, 0);
        check("rst_inh_busy", busy, 0);
        @(negedge CLK);
        reset_keyboard = 1'b0;

        // Reset mid-frame in DATA (byte 00 keeps data driven low)
        d0 = done_pulses;
        e0 = err_pulses;
        send_cmd(8'h00);
        wait_rts(got);
        check("rst_data_rts", got, 1);
        repeat (DEV_HALF) @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            dev_clk = 1'b0;
            repeat (DEV_HALF) @(negedge CLK);
            dev_clk = 1'b1;
            repeat (DEV_HALF) @(negedge CLK);
        end
        check("rst_data_state", dbg_state, ST_DATA);
        check("rst_data_pre_dat_low", dat_drive_low, 1);
        #5 reset_keyboard = 1'b1;
        #1;
        check("rst_data_lines", {clk_drive_low, dat_drive_low}, 2'b00);
        check("rst_data_busy", busy, 0);
        check("rst_data_ready", cmd_ready, 1);
        @(negedge CLK);
        reset_keyboard = 1'b0;
        repeat (20) @(negedge CLK);
        check("rst_data_no_pulses", {done_pulses - d0, err_pulses - e0}, 64'd0);
        check("rst_data_idle_state", dbg_state, ST_IDLE);

        // cmd_valid held while busy: exactly one frame, latched data used
        s0 = inhibit_starts;
        d0 = done_pulses;
        cmd_data  = PS2_CMD_ENABLE;
        cmd_valid = 1'b1;
        @(negedge CLK);
        cmd_data = 8'h55;
        dev_frame(11, 1'b1, bits, got);
        check("hold_rts", got, 1);
        ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            if (cmd_ready) ok = 1'b1;
            else @(negedge CLK);
        end
        cmd_valid = 1'b0;
        check("hold_idle", ok, 1);
        check("hold_frame_bits", bits, exp_frame(PS2_CMD_ENABLE));
        check("hold_inhibits", inhibit_starts - s0, 1);
        check("hold_done", done_pulses - d0, 1);
        repeat (100) @(negedge CLK);
        check("hold_no_second_frame", {busy, 31'(inhibit_starts - s0)}, {1'b0, 31'd1});

        check("pulse_width", wide_pulses, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
